// File: rtl/alu_issue_ctrl_pkg.sv
// alu_issue_ctrl_pkg
//   Shared definitions for the ALU issue controller, the alu instance and the
//   multi-cycle control FSM: issue-controller state encoding and ALU opcodes.
package alu_issue_ctrl_pkg;

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        LO    = 3'd1,
        HI    = 3'd2,
        CARRY = 3'd3,
        DONE  = 3'd4
    } issue_state_t;

    localparam logic [3:0] OPER_AND = 4'h0;
    localparam logic [3:0] OPER_OR  = 4'h1;
    localparam logic [3:0] OPER_XOR = 4'h2;
    localparam logic [3:0] OPER_NOT = 4'h3;
    localparam logic [3:0] OPER_ADD = 4'h4;
    localparam logic [3:0] OPER_SUB = 4'h5;

endpackage

// File: rtl/alu_issue_ctrl_flag_merge.sv
// alu_issue_ctrl_flag_merge
//   Combinational merge of the per-half ALU results into the flags of a wide
//   (2*OPERAND_WIDTH) operation.
//   Ports:
//     res_hi   in   upper half result (after any carry pass)
//     res_lo   in   lower half result
//     co_hi    in   carry out of the upper half pass
//     co_carry in   carry out of the carry pass (0 when no carry pass ran)
//     add_op   in   operation is ADD; carry is meaningful only for ADD
//     n,z,p,co out  merged wide flags
module alu_issue_ctrl_flag_merge #(
    parameter int OPERAND_WIDTH = 16
) (
    input  logic [OPERAND_WIDTH-1:0] res_hi,
    input  logic [OPERAND_WIDTH-1:0] res_lo,
    input  logic                     co_hi,
    input  logic                     co_carry,
    input  logic                     add_op,
    output logic                     n,
    output logic                     z,
    output logic                     p,
    output logic                     co
);

    always_comb begin
        n  = res_hi[OPERAND_WIDTH-1];
        z  = (res_hi == '0) && (res_lo == '0);
        p  = !n && !z;
        // Non-ADD wide operations work per half with no carry between them.
        co = add_op ? (co_hi | co_carry) : 1'b0;
    end

endmodule

// File: rtl/alu_issue_ctrl.sv
// alu_issue_ctrl
//   Initiator side of the ALU operand/flag interface. Takes requests over a
//   valid/ready handshake, drives the ALU operands/opcode from registers,
//   captures the result and flags, and returns them over a response channel.
//   Wide (2*OPERAND_WIDTH) requests run as chained passes: low half, high
//   half, and for ADD with a low-half carry an extra +1 pass on the high half.
//   Ports:
//     clk, rst                    clock, synchronous active-high reset
//     req_valid/req_ready         request handshake
//     req_wide, req_oper          request width select and ALU opcode
//     req_a, req_b                operands (narrow uses the low half)
//     alu_srcA/alu_srcB/alu_oper  registered ALU inputs
//     alu_result, alu_n/z/p/co    ALU outputs
//     rsp_valid/rsp_ready         response handshake
//     rsp_result, rsp_n/z/p/co    final result and flags
//     perf_passes                 ALU pass counter (only with ALU_ISSUE_PERF_EN)
//   Optional feature macro: ALU_ISSUE_PERF_EN
//
//   state | meaning
//   IDLE  | ready for a request
//   LO    | ALU working on the low half (or the whole narrow operation)
//   HI    | ALU working on the high half of a wide operation
//   CARRY | ALU adding the low-half carry into the high half
//   DONE  | response held until rsp_ready
module alu_issue_ctrl
    import alu_issue_ctrl_pkg::*;
#(
    parameter int OPERAND_WIDTH  = 16,
    parameter int NUM_OPERATIONS = 4
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         req_valid,
    output logic                         req_ready,
    input  logic                         req_wide,
    input  logic [NUM_OPERATIONS-1:0]    req_oper,
    input  logic [2*OPERAND_WIDTH-1:0]   req_a,
    input  logic [2*OPERAND_WIDTH-1:0]   req_b,
    output logic [OPERAND_WIDTH-1:0]     alu_srcA,
    output logic [OPERAND_WIDTH-1:0]     alu_srcB,
    output logic [NUM_OPERATIONS-1:0]    alu_oper,
    input  logic [OPERAND_WIDTH-1:0]     alu_result,
    input  logic                         alu_n,
    input  logic                         alu_z,
    input  logic                         alu_p,
    input  logic                         alu_co,
    output logic                         rsp_valid,
    input  logic                         rsp_ready,
    output logic [2*OPERAND_WIDTH-1:0]   rsp_result,
    output logic                         rsp_n,
    output logic                         rsp_z,
    output logic                         rsp_p,
    output logic                         rsp_co
`ifdef ALU_ISSUE_PERF_EN
    ,
    output logic [15:0]                  perf_passes
`endif
);

    localparam int W = OPERAND_WIDTH;
    localparam logic [NUM_OPERATIONS-1:0] ADD_OP = NUM_OPERATIONS'(OPER_ADD);

    issue_state_t state, state_nxt;

    logic [W-1:0] a_hi_q;
    logic [W-1:0] b_hi_q;
    logic         wide_q;
    logic [W-1:0] res_lo_q;
    logic         co_lo_q;
    logic         co_hi_q;

    logic accept;
    logic is_add;
    logic take_carry;
    logic mrg_co_hi, mrg_co_carry;
    logic mrg_n, mrg_z, mrg_p, mrg_co;

    assign req_ready  = (state == IDLE) && !rst;
    assign accept     = req_valid && req_ready;
    assign rsp_valid  = (state == DONE);
    // alu_oper still holds the request opcode during LO/HI, and CARRY is
    // only ever entered for ADD.
    assign is_add     = (alu_oper == ADD_OP);
    assign take_carry = is_add && co_lo_q;

    // In HI and CARRY the final high half is the live ALU result.
    assign mrg_co_hi    = (state == HI) ? alu_co : co_hi_q;
    assign mrg_co_carry = (state == CARRY) ? alu_co : 1'b0;

    alu_issue_ctrl_flag_merge #(
        .OPERAND_WIDTH(W)
    ) u_flag_merge (
        .res_hi   (alu_result),
        .res_lo   (res_lo_q),
        .co_hi    (mrg_co_hi),
        .co_carry (mrg_co_carry),
        .add_op   (is_add),
        .n        (mrg_n),
        .z        (mrg_z),
        .p        (mrg_p),
        .co       (mrg_co)
    );

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (accept) state_nxt = LO;
            LO:      state_nxt = wide_q ? HI : DONE;
            HI:      state_nxt = take_carry ? CARRY : DONE;
            CARRY:   state_nxt = DONE;
            DONE:    if (rsp_ready) state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= IDLE;
            alu_srcA   <= '0;
            alu_srcB   <= '0;
            alu_oper   <= '0;
            a_hi_q     <= '0;
            b_hi_q     <= '0;
            wide_q     <= 1'b0;
            res_lo_q   <= '0;
            co_lo_q    <= 1'b0;
            co_hi_q    <= 1'b0;
            rsp_result <= '0;
            rsp_n      <= 1'b0;
            rsp_z      <= 1'b0;
            rsp_p      <= 1'b0;
            rsp_co     <= 1'b0;
        end else begin
            state <= state_nxt;
            case (state)
                IDLE: begin
                    if (accept) begin
                        a_hi_q   <= req_a[2*W-1:W];
                        b_hi_q   <= req_b[2*W-1:W];
                        wide_q   <= req_wide;
                        alu_srcA <= req_a[W-1:0];
                        alu_srcB <= req_b[W-1:0];
                        alu_oper <= req_oper;
                    end
                end
                LO: begin
                    res_lo_q <= alu_result;
                    co_lo_q  <= alu_co;
                    if (wide_q) begin
                        alu_srcA <= a_hi_q;
                        alu_srcB <= b_hi_q;
                    end else begin
                        rsp_result <= {{W{1'b0}}, alu_result};
                        rsp_n      <= alu_n;
                        rsp_z      <= alu_z;
                        rsp_p      <= alu_p;
                        rsp_co     <= alu_co;
                    end
                end
                HI: begin
                    co_hi_q <= alu_co;
                    if (take_carry) begin
                        alu_srcA <= alu_result;
                        alu_srcB <= W'(1);
                        alu_oper <= ADD_OP;
                    end else begin
                        rsp_result <= {alu_result, res_lo_q};
                        rsp_n      <= mrg_n;
                        rsp_z      <= mrg_z;
                        rsp_p      <= mrg_p;
                        rsp_co     <= mrg_co;
                    end
                end
                CARRY: begin
                    rsp_result <= {alu_result, res_lo_q};
                    rsp_n      <= mrg_n;
                    rsp_z      <= mrg_z;
                    rsp_p      <= mrg_p;
                    rsp_co     <= mrg_co;
                end
                default: ;
            endcase
        end
    end

`ifdef ALU_ISSUE_PERF_EN
    always_ff @(posedge clk) begin
        if (rst) begin
            perf_passes <= '0;
        end else if ((state == LO || state == HI || state == CARRY) &&
                     (perf_passes != 16'hFFFF)) begin
            perf_passes <= perf_passes + 16'd1;
        end
    end
`endif

endmodule

// File: tb/tb_alu_issue_ctrl.sv
module tb_alu_issue_ctrl;
    import alu_issue_ctrl_pkg::*;

    logic        clk = 1'b0;
    logic        rst;
    logic        req_valid, req_ready, req_wide;
    logic [3:0]  req_oper;
    logic [31:0] req_a, req_b;
    logic [15:0] alu_srcA, alu_srcB;
    logic [3:0]  alu_oper;
    logic [15:0] alu_result;
    logic        alu_n, alu_z, alu_p, alu_co;
    logic        rsp_valid, rsp_ready;
    logic [31:0] rsp_result;
    logic        rsp_n, rsp_z, rsp_p, rsp_co;
`ifdef ALU_ISSUE_PERF_EN
    logic [15:0] perf_passes;
`endif

    always #5 clk = ~clk;

    alu_issue_ctrl dut (
        .clk        (clk),
        .rst        (rst),
        .req_valid  (req_valid),
        .req_ready  (req_ready),
        .req_wide   (req_wide),
        .req_oper   (req_oper),
        .req_a      (req_a),
        .req_b      (req_b),
        .alu_srcA   (alu_srcA),
        .alu_srcB   (alu_srcB),
        .alu_oper   (alu_oper),
        .alu_result (alu_result),
        .alu_n      (alu_n),
        .alu_z      (alu_z),
        .alu_p      (alu_p),
        .alu_co     (alu_co),
        .rsp_valid  (rsp_valid),
        .rsp_ready  (rsp_ready),
        .rsp_result (rsp_result),
        .rsp_n      (rsp_n),
        .rsp_z      (rsp_z),
        .rsp_p      (rsp_p),
        .rsp_co     (rsp_co)
`ifdef ALU_ISSUE_PERF_EN
        ,
        .perf_passes(perf_passes)
`endif
    );

    // 16-bit ALU environment model
    logic [16:0] sum17;
    always_comb begin
        sum17      = {1'b0, alu_srcA} + {1'b0, alu_srcB};
        alu_result = 16'h0;
        alu_co     = 1'b0;
        case (alu_oper)
            OPER_AND: alu_result = alu_srcA & alu_srcB;
            OPER_OR:  alu_result = alu_srcA | alu_srcB;
            OPER_XOR: alu_result = alu_srcA ^ alu_srcB;
            OPER_ADD: begin
                alu_result = sum17[15:0];
                alu_co     = sum17[16];
            end
            OPER_SUB: alu_result = alu_srcA - alu_srcB;
            default:  alu_result = 16'h0;
        endcase
        alu_n = alu_result[15];
        alu_z = (alu_result == 16'h0);
        alu_p = !alu_n && !alu_z;
    end

    typedef struct {
        logic [31:0] r;
        logic        n, z, p, co;
        int          lat;
    } exp_t;

    exp_t q[$];
    int tests_run = 0;
    int failed    = 0;

    // Reference: whole-width arithmetic, independent of the pass chaining.
    function automatic exp_t model(input logic wide, input logic [3:0] op,
                                   input logic [31:0] a, input logic [31:0] b);
        exp_t e;
        logic [16:0] s17;
        logic [32:0] s33;
        logic [15:0] r16;
        logic [31:0] r32;
        logic        c;
        c = 1'b0;
        if (!wide) begin
            s17 = {1'b0, a[15:0]} + {1'b0, b[15:0]};
            case (op)
                OPER_AND: r16 = a[15:0] & b[15:0];
                OPER_OR:  r16 = a[15:0] | b[15:0];
                OPER_XOR: r16 = a[15:0] ^ b[15:0];
                default: begin r16 = s17[15:0]; c = s17[16]; end
            endcase
            e.r = {16'h0, r16};
            e.n = r16[15];
            e.z = (r16 == 16'h0);
            e.lat = 1;
        end else begin
            s33 = {1'b0, a} + {1'b0, b};
            s17 = {1'b0, a[15:0]} + {1'b0, b[15:0]};
            e.lat = 2;
            case (op)
                OPER_AND: r32 = a & b;
                OPER_OR:  r32 = a | b;
                OPER_XOR: r32 = a ^ b;
                default: begin
                    r32 = s33[31:0];
                    c   = s33[32];
                    if (s17[16]) e.lat = 3;
                end
            endcase
            e.r = r32;
            e.n = r32[31];
            e.z = (r32 == 32'h0);
        end
        e.p  = !e.n && !e.z;
        e.co = c;
        return e;
    endfunction

    task automatic run_txn(input logic wide, input logic [3:0] op,
                           input logic [31:0] a, input logic [31:0] b,
                           input int hold, input string name);
        exp_t e;
        int lat;
        @(negedge clk);
        rsp_ready = (hold == 0);
        tests_run++;
        if (req_ready !== 1'b1) begin
            failed++;
            $display("FAIL %s req_ready_idle: got %b want 1", name, req_ready);
        end
        req_valid = 1'b1; req_wide = wide; req_oper = op; req_a = a; req_b = b;
        q.push_back(model(wide, op, a, b));
        @(posedge clk); #1;
        req_valid = 1'b0;
        req_a = $urandom; req_b = $urandom;
        lat = 0;
        while (rsp_valid !== 1'b1 && lat < 10) begin
            @(posedge clk); #1;
            lat++;
        end
        e = q.pop_front();
        tests_run++;
        if (lat !== e.lat) begin
            failed++;
            $display("FAIL %s latency: got %0d want %0d", name, lat, e.lat);
        end
        tests_run++;
        if ({rsp_result, rsp_n, rsp_z, rsp_p, rsp_co} !== {e.r, e.n, e.z, e.p, e.co}) begin
            failed++;
            $display("FAIL %s result/nzpc: got %h %b%b%b%b want %h %b%b%b%b", name,
                     rsp_result, rsp_n, rsp_z, rsp_p, rsp_co, e.r, e.n, e.z, e.p, e.co);
        end
        for (int i = 0; i < hold; i++) begin
            @(posedge clk); #1;
            tests_run++;
            if ({rsp_valid, req_ready, rsp_result} !== {1'b1, 1'b0, e.r}) begin
                failed++;
                $display("FAIL %s hold%0d valid/ready/result: got %b %b %h want 1 0 %h",
                         name, i, rsp_valid, req_ready, rsp_result, e.r);
            end
        end
        rsp_ready = 1'b1;
        @(posedge clk); #1;
        tests_run++;
        if ({rsp_valid, req_ready} !== 2'b01) begin
            failed++;
            $display("FAIL %s after_handshake valid/ready: got %b%b want 01",
                     name, rsp_valid, req_ready);
        end
    endtask

    task automatic test_reset();
        rst = 1'b1; req_valid = 1'b0; req_wide = 1'b0; req_oper = 4'h0;
        req_a = 32'h0; req_b = 32'h0; rsp_ready = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        tests_run++;
        if ({req_ready, rsp_valid, rsp_result, rsp_n, rsp_z, rsp_p, rsp_co,
             alu_srcA, alu_srcB, alu_oper} !== 74'h0) begin
            failed++;
            $display("FAIL reset_outputs: got rdy=%b v=%b r=%h a=%h b=%h op=%h want all 0",
                     req_ready, rsp_valid, rsp_result, alu_srcA, alu_srcB, alu_oper);
        end
        rst = 1'b0;
        @(posedge clk); #1;
        tests_run++;
        if (req_ready !== 1'b1) begin
            failed++;
            $display("FAIL reset_release req_ready: got %b want 1", req_ready);
        end
    endtask

    task automatic test_narrow();
        run_txn(1'b0, OPER_ADD, 32'h0000_0003, 32'h0000_0004, 0, "narrow_add");
`ifdef ALU_ISSUE_PERF_EN
        tests_run++;
        if (perf_passes !== 16'd1) begin
            failed++;
            $display("FAIL perf_narrow: got %0d want 1", perf_passes);
        end
`endif
        run_txn(1'b0, OPER_ADD, 32'hABCD_FFFF, 32'h5555_0001, 0, "narrow_add_co");
        run_txn(1'b0, OPER_AND, 32'hFFFF_8F0F, 32'h1234_F0FF, 0, "narrow_and");
        run_txn(1'b0, OPER_XOR, 32'h0000_5A5A, 32'hFFFF_5A5A, 0, "narrow_xor_z");
    endtask

    task automatic test_wide_add();
        run_txn(1'b1, OPER_ADD, 32'h0001_FFFF, 32'h0000_0001, 0, "wide_add_carry");
        run_txn(1'b1, OPER_ADD, 32'hFFFF_FFFF, 32'h0000_0001, 0, "wide_add_wrap");
        run_txn(1'b1, OPER_ADD, 32'h1234_0001, 32'h0000_0001, 0, "wide_add_nocarry");
        run_txn(1'b1, OPER_ADD, 32'hF000_0000, 32'h2000_0000, 0, "wide_add_hico");
    endtask

    task automatic test_wide_logic();
        run_txn(1'b1, OPER_OR,  32'h8000_0000, 32'h0000_0001, 0, "wide_or_neg");
        run_txn(1'b1, OPER_AND, 32'hFFFF_FFFF, 32'h0000_0000, 0, "wide_and_zero");
    endtask

    task automatic test_backpressure();
        run_txn(1'b0, OPER_ADD, 32'h0000_1111, 32'h0000_2222, 5, "bp_narrow");
        run_txn(1'b1, OPER_ADD, 32'h0000_FFFF, 32'h0000_FFFF, 5, "bp_wide");
    endtask

    task automatic test_back_to_back();
        run_txn(1'b1, OPER_XOR, 32'h1234_5678, 32'h1234_5678, 0, "b2b_0");
        run_txn(1'b0, OPER_OR,  32'h0000_0000, 32'h0000_0000, 0, "b2b_1");
        run_txn(1'b1, OPER_ADD, 32'h7FFF_FFFF, 32'h0000_0001, 0, "b2b_2");
    endtask

    task automatic test_random();
        logic [3:0] ops [4];
        ops[0] = OPER_AND; ops[1] = OPER_OR; ops[2] = OPER_XOR; ops[3] = OPER_ADD;
        for (int i = 0; i < 16; i++) begin
            run_txn(1'($urandom_range(0, 1)), ops[$urandom_range(0, 3)],
                    $urandom, $urandom, 0, "random");
        end
    endtask

    task automatic test_reset_mid();
        int seen;
        @(negedge clk);
        rsp_ready = 1'b1;
        req_valid = 1'b1; req_wide = 1'b1; req_oper = OPER_ADD;
        req_a = 32'hFFFF_FFFF; req_b = 32'h0000_0001;
        @(posedge clk); #1;
        req_valid = 1'b0;
        @(posedge clk); #1;
        tests_run++;
        if ({alu_srcA, alu_srcB} !== {16'hFFFF, 16'h0000}) begin
            failed++;
            $display("FAIL midrst_in_hi srcA/srcB: got %h %h want ffff 0000", alu_srcA, alu_srcB);
        end
        rst = 1'b1;
        @(posedge clk); #1;
        tests_run++;
        if ({req_ready, rsp_valid, alu_srcA, alu_srcB, alu_oper} !== 38'h0) begin
            failed++;
            $display("FAIL midrst_outputs: got rdy=%b v=%b a=%h b=%h op=%h want all 0",
                     req_ready, rsp_valid, alu_srcA, alu_srcB, alu_oper);
        end
`ifdef ALU_ISSUE_PERF_EN
        tests_run++;
        if (perf_passes !== 16'd0) begin
            failed++;
            $display("FAIL midrst_perf: got %0d want 0", perf_passes);
        end
`endif
        rst = 1'b0;
        seen = 0;
        repeat (5) begin
            @(posedge clk); #1;
            if (rsp_valid !== 1'b0) seen++;
        end
        tests_run++;
        if (seen != 0 || req_ready !== 1'b1) begin
            failed++;
            $display("FAIL midrst_no_response: got %0d valid cycles rdy=%b want 0 rdy=1",
                     seen, req_ready);
        end
    endtask

    initial begin
        test_reset();
        test_narrow();
        test_wide_add();
        test_wide_logic();
        test_backpressure();
        test_back_to_back();
        test_random();
        test_reset_mid();
        run_txn(1'b1, OPER_ADD, 32'h0001_8000, 32'h0002_8000, 0, "post_reset");
        $display("[TB] %0d tests run, %0d failed", tests_run, failed);
        $finish;
    end

endmodule
